// File: rtl/trajectory_trail.sv
`default_nettype none
// ============================================================================
// Module   : trajectory_trail
// Purpose  : Ring buffer of recent ball centroids rendered as age-faded dots,
//            producing a 24-bit overlay pixel (0 = transparent).
// Revision : 1.0 - initial release
// ============================================================================
module trajectory_trail #(
    parameter int          DEPTH        = 8,
    parameter int          RADIUS       = 3,
    parameter int          SAMPLE_EVERY = 2,
    parameter logic [23:0] BASE_COLOR   = 24'hFFCC00
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        new_frame_in,
    input  logic [10:0] centroid_x_in,
    input  logic [9:0]  centroid_y_in,
    input  logic        centroid_valid_in,
    input  logic        enable_in,
    input  logic        clear_in,
    output logic [23:0] trajectory_pixel_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FC_W  = (SAMPLE_EVERY > 1) ? $clog2(SAMPLE_EVERY) : 1;

    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(SAMPLE_EVERY - 1);
    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [PTR_W:0]   DEPTH_WIDE = (PTR_W + 1)'(DEPTH);
    localparam logic [11:0]      RADIUS_12  = 12'(RADIUS);
    localparam logic [7:0]       BASE_R     = BASE_COLOR[23:16];
    localparam logic [7:0]       BASE_G     = BASE_COLOR[15:8];
    localparam logic [7:0]       BASE_B     = BASE_COLOR[7:0];

    logic [10:0]      entry_x_q [DEPTH];
    logic [9:0]       entry_y_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [FC_W-1:0]  fcnt_q,   fcnt_d;
    logic [DEPTH-1:0] hit_q,    hit_d;
    logic [23:0]      pix_q,    pix_d;

    logic w_sample;
    logic w_push;

    assign w_sample = new_frame_in && (fcnt_q == FC_LAST) && enable_in && centroid_valid_in;
    assign w_push   = w_sample && !clear_in;

    // Clear has priority over both the frame counter and any coincident push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        fcnt_d   = fcnt_q;
        if (clear_in) begin
            wr_ptr_d = '0;
            count_d  = '0;
            fcnt_d   = '0;
        end else begin
            if (new_frame_in) begin
                fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
            end
            if (w_push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
                if (count_q != CNT_FULL) begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_x_q[i] <= '0;
                entry_y_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fcnt_q   <= fcnt_d;
            if (w_push) begin
                entry_x_q[wr_ptr_q] <= centroid_x_in;
                entry_y_q[wr_ptr_q] <= centroid_y_in;
            end
        end
    end

    // Stage 1: one comparator pair per age; age k lives at (wr_ptr-1-k) mod DEPTH.
    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [PTR_W:0]     w_sum;
        logic [PTR_W-1:0]   w_idx;
        logic signed [11:0] w_dx;
        logic signed [11:0] w_dy;
        logic [11:0]        w_adx;
        logic [11:0]        w_ady;
        logic               w_valid;

        assign w_sum   = {1'b0, wr_ptr_q} + (PTR_W + 1)'(DEPTH - 1 - k);
        assign w_idx   = (w_sum >= DEPTH_WIDE) ? PTR_W'(w_sum - DEPTH_WIDE) : PTR_W'(w_sum);
        assign w_dx    = $signed({1'b0, hcount_in}) - $signed({1'b0, entry_x_q[w_idx]});
        assign w_dy    = $signed({2'b00, vcount_in}) - $signed({2'b00, entry_y_q[w_idx]});
        assign w_adx   = w_dx[11] ? 12'(-w_dx) : 12'(w_dx);
        assign w_ady   = w_dy[11] ? 12'(-w_dy) : 12'(w_dy);
        assign w_valid = CNT_W'(k) < count_q;
        assign hit_d[k] = w_valid && (w_adx <= RADIUS_12) && (w_ady <= RADIUS_12);
    end

    // Stage 2: the newest hitting point wins; colour halves with every step of age.
    always_comb begin
        pix_d = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                pix_d = {BASE_R >> k, BASE_G >> k, BASE_B >> k};
            end
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            hit_q <= '0;
            pix_q <= '0;
        end else begin
            hit_q <= hit_d;
            pix_q <= pix_d;
        end
    end

    assign trajectory_pixel_out = pix_q;

endmodule
`default_nettype wire
